pair_cfg_ctrl: RTL

PAIR_CFG_CTRL -- requirements
Module: pair_cfg_ctrl

---
 rtl/pair_cfg_ctrl_pkg.sv | 33 +++
 rtl/pair_cfg_bank.sv | 81 ++++++++
 rtl/pair_cfg_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pair_cfg_ctrl_pkg.sv
// Shared types, config address map and FSM encoding for the pair config controller.
// Readback of the shadow bank is enabled with PAIR_CFG_READBACK_EN.
package pair_cfg_ctrl_pkg;

    typedef logic [31:0] int32_t;
    typedef logic [1:0]  int2_t;
    typedef logic        bool;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 60;
    localparam int unsigned OP_W   = 8;

    localparam logic [ADDR_W-1:0] CONS_BASE = 5'd0;
    localparam logic [ADDR_W-1:0] SEL_LO    = 5'd20;
    localparam logic [ADDR_W-1:0] SEL_HI    = 5'd21;
    localparam logic [ADDR_W-1:0] OPS       = 5'd22;
    localparam logic [ADDR_W-1:0] ADDR_MAX  = 5'd22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_QUIESCE,
        ST_SWAP
    } state_e;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [OP_W-1:0]  arith_op;
        logic [OP_W-1:0]  rel_op;
    } cfg_ops_t;

endpackage

// File: rtl/pair_cfg_bank.sv
// Shadow/active register pair: writes land in shadow, swap copies shadow to active.
// PAIR_CFG_READBACK_EN adds a combinational shadow read port.
module pair_cfg_bank
    import pair_cfg_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CONS = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  int32_t                     wr_data,
    input  logic                       swap,
    output logic [NUM_CONS*DATA_W-1:0] act_cons,
    output cfg_ops_t                   act_ops
`ifdef PAIR_CFG_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]          rd_addr,
    output int32_t                     rd_data
`endif
);

    logic [NUM_CONS*DATA_W-1:0] shd_cons_q;
    logic [NUM_CONS*DATA_W-1:0] act_cons_q;
    cfg_ops_t                   shd_ops_q;
    cfg_ops_t                   act_ops_q;

    // Shadow bank; addresses outside the map leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_cons_q <= '0;
            shd_ops_q  <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CONS; i++) begin
                if (wr_addr == CONS_BASE + ADDR_W'(i)) begin
                    shd_cons_q[i*DATA_W +: DATA_W] <= wr_data;
                end
            end
            case (wr_addr)
                SEL_LO: shd_ops_q.sel[31:0]       <= wr_data;
                SEL_HI: shd_ops_q.sel[SEL_W-1:32] <= wr_data[27:0];
                OPS: begin
                    shd_ops_q.rel_op   <= wr_data[7:0];
                    shd_ops_q.arith_op <= wr_data[15:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cons_q <= '0;
            act_ops_q  <= '0;
        end else if (swap) begin
            act_cons_q <= shd_cons_q;
            act_ops_q  <= shd_ops_q;
        end
    end

    assign act_cons = act_cons_q;
    assign act_ops  = act_ops_q;

`ifdef PAIR_CFG_READBACK_EN
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CONS; i++) begin
            if (rd_addr == CONS_BASE + ADDR_W'(i)) begin
                rd_data = shd_cons_q[i*DATA_W +: DATA_W];
            end
        end
        case (rd_addr)
            SEL_LO:  rd_data = shd_ops_q.sel[31:0];
            SEL_HI:  rd_data = DATA_W'(shd_ops_q.sel[SEL_W-1:32]);
            OPS:     rd_data = {16'b0, shd_ops_q.arith_op, shd_ops_q.rel_op};
            default: ;
        endcase
    end
`endif

endmodule

// File: rtl/pair_cfg_ctrl.sv
// Double-buffered config controller: drains the packet path before swapping banks.
// PAIR_CFG_READBACK_EN adds rd_addr/rd_data shadow readback.
module pair_cfg_ctrl
    import pair_cfg_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned NUM_CONS     = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [DATA_W-1:0]          cfg_data,
    input  logic                       cfg_commit,
    output logic                       commit_done,
    output logic                       cfg_loaded,
    output logic                       err_addr,
    input  logic                       pkt_valid_i,
    output logic                       pkt_ready_o,
    input  logic [DATA_W-1:0]          pkt_1_i,
    input  logic [DATA_W-1:0]          pkt_2_i,
    output logic                       pkt_valid_o,
    output logic [DATA_W-1:0]          pkt_1_o,
    output logic [DATA_W-1:0]          pkt_2_o,
    output logic [NUM_CONS*DATA_W-1:0] act_cons,
    output logic [SEL_W-1:0]           act_sel,
    output logic [OP_W-1:0]            act_rel_op,
    output logic [OP_W-1:0]            act_arith_op
`ifdef PAIR_CFG_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data
`endif
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_e             state_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               wr_en;
    logic               pkt_acc;
    cfg_ops_t           act_ops;

    assign wr_en   = cfg_valid && cfg_ready;
    assign pkt_acc = pkt_valid_i && pkt_ready_o;

    // Ready flags are decoded from the next state so they are registered yet in step with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_q     <= '0;
            commit_done <= 1'b0;
            cfg_loaded  <= 1'b0;
            cfg_ready   <= 1'b1;
            pkt_ready_o <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (cfg_commit) begin
                        state_q     <= ST_QUIESCE;
                        drain_q     <= DRAIN_W'(DRAIN_CYCLES);
                        cfg_ready   <= 1'b0;
                        pkt_ready_o <= 1'b0;
                    end
                end
                ST_QUIESCE: begin
                    if (drain_q <= DRAIN_W'(1)) begin
                        state_q     <= ST_SWAP;
                        drain_q     <= '0;
                        commit_done <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
                ST_SWAP: begin
                    state_q     <= ST_RUN;
                    cfg_loaded  <= 1'b1;
                    cfg_ready   <= 1'b1;
                    pkt_ready_o <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_addr <= 1'b0;
        end else if (wr_en && (cfg_addr > ADDR_MAX)) begin
            err_addr <= 1'b1;
        end
    end

    // One-cycle packet register toward the atom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid_o <= 1'b0;
            pkt_1_o     <= '0;
            pkt_2_o     <= '0;
        end else begin
            pkt_valid_o <= pkt_acc;
            if (pkt_acc) begin
                pkt_1_o <= pkt_1_i;
                pkt_2_o <= pkt_2_i;
            end
        end
    end

    pair_cfg_bank #(
        .NUM_CONS (NUM_CONS)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .swap     (state_q == ST_SWAP),
        .act_cons (act_cons),
        .act_ops  (act_ops)
`ifdef PAIR_CFG_READBACK_EN
        ,
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
`endif
    );

    assign act_sel      = act_ops.sel;
    assign act_rel_op   = act_ops.rel_op;
    assign act_arith_op = act_ops.arith_op;

endmodule
